fadd_pipe: RTL and testbench
============================

Name: fadd_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point adder/subtractor. Next generation of the team's combinational fadd.
- Generic in exponent/mantissa width and adds a subtract mode.
- Three-stage pipeline with valid/ready handshake on both sides, so it sits directly between the FPU issue queue and the writeback arbiter.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_sub  in  1  1: compute s - t; 0: s + t.
- in_s  in  W  operand s.
- in_t  in  W  operand t.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_d  out  W  result.
- out_overflow  out  1  finite inputs produced ±inf.
- out_underflow  out  1  nonzero exact result flushed to zero.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: all stage valid bits cleared; out_valid=0, out_d=0, out_overflow=0, out_underflow=0. Reset mid-operation discards all in-flight results; no output appears after reset release until new inputs are accepted.
- Handshake and stall:
  - Transfer on in_valid&&in_ready, and on out_valid&&out_ready.
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_ready, no other path).
  - When advance=0 every stage holds its register contents.
  - Bubbles are not collapsed.
- Latency and throughput: exactly 3 cycles from accept to out_valid with no stall; throughput 1 per cycle.
- Order: results leave in acceptance order; none dropped or duplicated under arbitrary out_ready patterns.
- Stage 1 (unpack/align):
  - Flip t's sign when in_sub=1.
  - Classify each operand as zero, denormal, inf or NaN. Denormal inputs are flushed to signed zero.
  - Compare magnitudes {exp,man}; the larger operand is g, the smaller is l.
  - Right-shift l's significand (hidden 1 restored) by the exponent difference, saturated at MAN_W+3.
  - Keep guard and round bits; OR all shifted-out bits into sticky.
- Stage 2 (add/normalise):
  - Effective op is add if signs are equal, else subtract. Significand width is MAN_W+4 plus carry.
  - Carry: shift right 1 and exp+1, folding the shifted bit into sticky.
  - Otherwise a leading-zero count drives a left shift, with exp-lzc.
  - An exact zero result sets a zero flag.
- Stage 3 (round/pack):
  - Round to nearest, ties to even, using guard/round/sticky.
  - Rounding carry-out renormalises and adds exp+1.
  - Exponent ≥ 2^EXP_W-1 gives ±inf with out_overflow=1.
  - Exponent ≤ 0 gives signed zero with out_underflow=1.
- Special cases, in priority order:
  - Any NaN input, or inf + (-inf) after the in_sub flip: canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0). Flags 0.
  - Single inf, or two infs of equal sign: that inf. Flags 0.
  - Exact cancellation: +0.
  - Both operands zero: -0 only if both are -0 after the flip.
  - One zero operand: the other operand, unchanged.
- Width rules: all exponent arithmetic in EXP_W+2 bit signed; no silent wrap.

Decomposition:
- fpu_pkg holds:
  - EXP_W/MAN_W defaults and derived W and BIAS.
  - Field-extract functions (sign/exp/man).
  - Classification function returning a 4-bit class enum (ZERO/NORM/INF/NAN).
  - Canonical-qNaN constant function.
- One sub-module, lzc: parametrised leading-zero counter (input width N, output clog2(N+1)), instantiated in stage 2.

Test Plan:
- 0x3F800000 + 0x3F800000, sub=0 → 0x40000000 after 3 cycles, flags 0.
- 0x3F800000 with sub=1 against 0x3F800000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- Ties-to-even:
  - 0x4B800000 + 0x3F800000 → 0x4B800000.
  - 0x4B800001 + 0x3F800000 → 0x4B800002.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with out_overflow=1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7FA00000 + 0x3F800000 → 0x7FC00000.
- Underflow: 0x00800001 - 0x00800000 → 0x00000000 with out_underflow=1. Denormal input 0x00000001 + 0x3F800000 → 0x3F800000.
- Backpressure:
  - Issue 8 back-to-back ops (k + 1.0, k = 1..8) with out_ready toggling 0 for 5 cycles then random.
  - Require all 8 results in order, and in_ready low exactly when out_valid && !out_ready.
  - Assert rstn low mid-stream: out_valid=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared floating-point helpers: default field widths, field extraction,
// operand classification and the canonical quiet NaN.
package fpu_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  // Widest word the helpers accept; callers size-cast results down.
  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    CL_ZERO = 4'b0001,
    CL_NORM = 4'b0010,
    CL_INF  = 4'b0100,
    CL_NAN  = 4'b1000
  } fp_class_e;

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic fp_sign(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
    return |(w & (MAX_W'(1) << (exp_w + man_w)));
  endfunction

  function automatic logic [MAX_W-1:0] fp_exp(input logic [MAX_W-1:0] w, input int exp_w, input int man_w);
    return (w >> man_w) & ((MAX_W'(1) << exp_w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] fp_man(input logic [MAX_W-1:0] w, input int man_w);
    return w & ((MAX_W'(1) << man_w) - MAX_W'(1));
  endfunction

  // Denormals classify as zero so they are flushed on input.
  function automatic fp_class_e fp_class(input logic exp_ones, input logic exp_zero, input logic man_zero);
    if (exp_zero) return CL_ZERO;
    if (exp_ones) return man_zero ? CL_INF : CL_NAN;
    return CL_NORM;
  endfunction

  function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return (((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w) | (MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fadd_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns N.
module lzc #(
  parameter int N  = 27,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  d,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (d[i]) cnt = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point add/subtract with valid/ready on both
// sides: unpack/align, add/normalise, round/pack.
module fadd_pipe import fpu_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [EXP_W+MAN_W:0]   in_s,
  input  logic [EXP_W+MAN_W:0]   in_t,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_d,
  output logic                   out_overflow,
  output logic                   out_underflow
);

  localparam int W    = fp_width(EXP_W, MAN_W);
  localparam int E2   = EXP_W + 2;
  localparam int M3   = MAN_W + 3;
  localparam int N    = MAN_W + 4;
  localparam int SH_W = $clog2(MAN_W + 4);
  localparam int LZ_W = $clog2(N + 1);
  localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [E2-1:0] SH_MAX = E2'(M3);
  localparam logic signed [E2-1:0] E_MAX  = E2'((1 << EXP_W) - 1);
  localparam logic signed [E2-1:0] E_ZERO = '0;
  localparam logic signed [E2-1:0] E_ONE  = E2'(1);

  // Valid/ready: a transfer happens when valid && ready on a rising edge.
  // The whole pipe advances together; bubbles are carried, never collapsed.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: unpack / classify / align ----------------
  logic             s_sign, t_sign, g_sign, l_sign, swap, sticky, spec;
  logic [EXP_W-1:0] s_exp, t_exp, g_exp, l_exp;
  logic [MAN_W-1:0] s_man, t_man, g_man, l_man;
  fp_class_e        s_cls, t_cls;
  logic signed [E2-1:0] diff;
  logic [SH_W-1:0]  sh;
  logic [M3-1:0]    l_ext, l_shift, mask;
  logic [W-1:0]     spec_w;

  always_comb begin
    s_sign = fp_sign(MAX_W'(in_s), EXP_W, MAN_W);
    t_sign = fp_sign(MAX_W'(in_t), EXP_W, MAN_W) ^ in_sub;
    s_exp  = EXP_W'(fp_exp(MAX_W'(in_s), EXP_W, MAN_W));
    t_exp  = EXP_W'(fp_exp(MAX_W'(in_t), EXP_W, MAN_W));
    s_man  = MAN_W'(fp_man(MAX_W'(in_s), MAN_W));
    t_man  = MAN_W'(fp_man(MAX_W'(in_t), MAN_W));
    s_cls  = fp_class(&s_exp, ~|s_exp, ~|s_man);
    t_cls  = fp_class(&t_exp, ~|t_exp, ~|t_man);
    swap   = {t_exp, t_man} > {s_exp, s_man};
    g_sign = swap ? t_sign : s_sign;
    g_exp  = swap ? t_exp  : s_exp;
    g_man  = swap ? t_man  : s_man;
    l_sign = swap ? s_sign : t_sign;
    l_exp  = swap ? s_exp  : t_exp;
    l_man  = swap ? s_man  : t_man;
    diff    = E2'(g_exp) - E2'(l_exp);
    sh      = (diff > SH_MAX) ? SH_W'(M3) : SH_W'(diff);
    l_ext   = {1'b1, l_man, 2'b00};
    l_shift = l_ext >> sh;
    mask    = ~({M3{1'b1}} << sh);
    sticky  = |(l_ext & mask);

    spec   = 1'b1;
    if (s_cls == CL_NAN || t_cls == CL_NAN ||
        (s_cls == CL_INF && t_cls == CL_INF && s_sign != t_sign))
      spec_w = QNAN;
    else if (s_cls == CL_INF)
      spec_w = {s_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (t_cls == CL_INF)
      spec_w = {t_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (s_cls == CL_ZERO && t_cls == CL_ZERO)
      spec_w = {s_sign & t_sign, {(W-1){1'b0}}};
    else if (s_cls == CL_ZERO)
      spec_w = {t_sign, t_exp, t_man};
    else if (t_cls == CL_ZERO)
      spec_w = {s_sign, s_exp, s_man};
    else begin
      spec   = 1'b0;
      spec_w = '0;
    end
  end

  logic                 s1_valid, s1_spec, s1_sign, s1_eff_sub;
  logic [W-1:0]         s1_spec_w;
  logic signed [E2-1:0] s1_exp;
  logic [N-1:0]         s1_sig_g, s1_sig_l;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0; s1_spec <= 1'b0; s1_spec_w <= '0; s1_sign <= 1'b0;
      s1_eff_sub <= 1'b0; s1_exp <= '0; s1_sig_g <= '0; s1_sig_l <= '0;
    end else if (advance) begin
      s1_valid   <= in_valid;
      s1_spec    <= spec;
      s1_spec_w  <= spec_w;
      s1_sign    <= g_sign;
      s1_eff_sub <= g_sign ^ l_sign;
      s1_exp     <= E2'(g_exp);
      s1_sig_g   <= {1'b1, g_man, 3'b000};
      s1_sig_l   <= {l_shift, sticky};
    end
  end

  // ---------------- stage 2: add / normalise ----------------
  logic [N:0]           sum;
  logic [LZ_W-1:0]      lz;
  logic [N-1:0]         norm;
  logic signed [E2-1:0] n_exp;

  lzc #(.N(N)) u_lzc (.d(sum[N-1:0]), .cnt(lz));

  always_comb begin
    sum = s1_eff_sub ? ({1'b0, s1_sig_g} - {1'b0, s1_sig_l})
                     : ({1'b0, s1_sig_g} + {1'b0, s1_sig_l});
    if (sum[N]) begin
      norm  = {sum[N:2], sum[1] | sum[0]};
      n_exp = s1_exp + E_ONE;
    end else begin
      norm  = sum[N-1:0] << lz;
      n_exp = s1_exp - E2'(lz);
    end
  end

  logic                 s2_valid, s2_spec, s2_sign, s2_zero;
  logic [W-1:0]         s2_spec_w;
  logic signed [E2-1:0] s2_exp;
  logic [N-1:0]         s2_norm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0; s2_spec <= 1'b0; s2_spec_w <= '0; s2_sign <= 1'b0;
      s2_zero <= 1'b0; s2_exp <= '0; s2_norm <= '0;
    end else if (advance) begin
      s2_valid  <= s1_valid;
      s2_spec   <= s1_spec;
      s2_spec_w <= s1_spec_w;
      s2_sign   <= s1_sign;
      s2_zero   <= (sum == '0);
      s2_exp    <= n_exp;
      s2_norm   <= norm;
    end
  end

  // ---------------- stage 3: round (nearest-even) / pack ----------------
  logic                 round_up;
  logic [MAN_W+1:0]     rsig;
  logic [MAN_W-1:0]     r_man;
  logic signed [E2-1:0] r_exp;
  logic [W-1:0]         res_d;
  logic                 res_ovf, res_udf;

  always_comb begin
    round_up = s2_norm[2] & (s2_norm[1] | s2_norm[0] | s2_norm[3]);
    rsig     = {1'b0, s2_norm[N-1:3]} + (MAN_W+2)'(round_up);
    if (rsig[MAN_W+1]) begin
      r_man = rsig[MAN_W:1];
      r_exp = s2_exp + E_ONE;
    end else begin
      r_man = rsig[MAN_W-1:0];
      r_exp = s2_exp;
    end
    res_ovf = 1'b0;
    res_udf = 1'b0;
    if (s2_spec)
      res_d = s2_spec_w;
    else if (s2_zero)
      res_d = '0;
    else if (r_exp >= E_MAX) begin
      res_d   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (r_exp <= E_ZERO) begin
      res_d   = {s2_sign, {(W-1){1'b0}}};
      res_udf = 1'b1;
    end else
      res_d = {s2_sign, r_exp[EXP_W-1:0], r_man};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0; out_d <= '0; out_overflow <= 1'b0; out_underflow <= 1'b0;
    end else if (advance) begin
      out_valid     <= s2_valid;
      out_d         <= res_d;
      out_overflow  <= res_ovf;
      out_underflow <= res_udf;
    end
  end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed bench for fadd_pipe: hand-computed single-precision vectors,
// latency, backpressure ordering and mid-stream reset.
module tb_fadd_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_s, in_t;
  logic         out_valid, out_ready;
  logic [W-1:0] out_d;
  logic         out_overflow, out_underflow;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];
  logic [W-1:0] k_tab[0:9];

  fadd_pipe dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_s(in_s), .in_t(in_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d),
    .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- comparison helper ----
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---- driver: hold operands until accepted, bounded wait ----
  task automatic send(input logic sub, input logic [W-1:0] s, input logic [W-1:0] t,
                      input logic [W-1:0] d, input logic ovf, input logic udf);
    logic rdy;
    int   n;
    in_valid = 1'b1; in_sub = sub; in_s = s; in_t = t;
    n = 0;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 200);
    if (!rdy) check("send_timeout", 64'(rdy), 64'(1));
    else exp_q.push_back({ovf, udf, d});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // ---- scoreboard / handshake monitor ----
  always @(negedge clk) begin
    if (rstn) begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'(0));
        else check("result", 64'({out_overflow, out_underflow, out_d}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---- directed sequence ----
  initial begin
    k_tab[0] = 32'h3F800000; k_tab[1] = 32'h3F800000; k_tab[2] = 32'h40000000;
    k_tab[3] = 32'h40400000; k_tab[4] = 32'h40800000; k_tab[5] = 32'h40A00000;
    k_tab[6] = 32'h40C00000; k_tab[7] = 32'h40E00000; k_tab[8] = 32'h41000000;
    k_tab[9] = 32'h41100000;
    rstn = 1'b0; in_valid = 1'b0; in_sub = 1'b0; in_s = '0; in_t = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_d", 64'(out_d), 64'(0));
    check("rst_flags", 64'({out_overflow, out_underflow}), 64'(0));
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // 1.0 + 1.0 with exact latency check
    send(1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    @(negedge clk); check("lat_c1", 64'(out_valid), 64'(0));
    @(negedge clk); check("lat_c2", 64'(out_valid), 64'(0));
    @(negedge clk); check("lat_c3", 64'(out_valid), 64'(1));
    @(posedge clk); #1;

    send(1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    send(1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    send(1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000, 1'b0, 1'b0);
    send(1'b0, 32'h4B800001, 32'h3F800000, 32'h4B800002, 1'b0, 1'b0);
    send(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    send(1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0);
    send(1'b0, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    send(1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
    send(1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    send(1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0);
    send(1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    send(1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0);
    send(1'b1, 32'h00000000, 32'h40400000, 32'hC0400000, 1'b0, 1'b0);
    drain();

    // backpressure: 8 back-to-back ops, out_ready low 5 cycles then random
    fork
      begin
        for (int k = 1; k <= 8; k++)
          send(1'b0, k_tab[k], 32'h3F800000, k_tab[k+1], 1'b0, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        repeat (40) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // mid-stream reset with a full, stalled pipe
    out_ready = 1'b0;
    send(1'b0, k_tab[2], 32'h3F800000, k_tab[3], 1'b0, 1'b0);
    send(1'b0, k_tab[3], 32'h3F800000, k_tab[4], 1'b0, 1'b0);
    send(1'b0, k_tab[4], 32'h3F800000, k_tab[5], 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_d", 64'(out_d), 64'(0));
    exp_q.delete();
    @(posedge clk); #2 rstn = 1'b1; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk); check("post_rst_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    send(1'b0, k_tab[5], 32'h3F800000, k_tab[6], 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
